// File: rtl/w5300_reg_seq_pkg.sv
// Shared types for the W5300 register-access sequencer: bus operation
// encoding, sequencer states and the address step helper.
package w5300_reg_seq_pkg;

    typedef enum logic {
        ADDR_OP_RD = 1'b0,
        ADDR_OP_WR = 1'b1
    } addr_operation_e;

    typedef enum logic [1:0] {
        SEQ_WAIT_INIT = 2'd0,
        SEQ_IDLE      = 2'd1,
        SEQ_BURST     = 2'd2,
        SEQ_DRAIN     = 2'd3
    } seq_state_e;

    localparam logic [9:0] ADDR_STEP = 10'd2;

    // Word step with 10-bit wrap; bit0 is carried through untouched.
    function automatic logic [9:0] next_addr(input logic [9:0] addr, input logic inc);
        logic [8:0] step_s;
        step_s = ADDR_STEP[9:1];
        if (inc) begin
            next_addr = {addr[9:1] + step_s, addr[0]};
        end else begin
            next_addr = addr;
        end
    endfunction

endpackage

// File: rtl/w5300_reg_seq.sv
// Burst register-access sequencer: turns read/write burst requests into one
// W5300 interface access per word, streaming write data in and read data out.
module w5300_reg_seq
    import w5300_reg_seq_pkg::*;
#(
    parameter logic [9:0] IDLE_ADDR = 10'h000,
    parameter int         MAX_LEN_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_op,
    input  logic [9:0]           req_addr,
    input  logic [MAX_LEN_W-1:0] req_len,
    input  logic                 req_inc,
    input  logic [15:0]          wr_data,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    output logic [15:0]          rd_data,
    output logic                 rd_valid,
    output logic                 done,
    output logic                 busy,
    output logic [10:0]          ctrl_addr,
    output logic [15:0]          ctrl_wr_data,
    input  logic [15:0]          ctrl_rd_data,
    input  logic                 ctrl_op_state
);

    localparam logic [10:0]          IDLE_CMD = {ADDR_OP_RD, IDLE_ADDR};
    localparam logic [MAX_LEN_W-1:0] LEN_ONE  = {{(MAX_LEN_W-1){1'b0}}, 1'b1};

    seq_state_e           state_q, state_d;
    addr_operation_e      op_q, op_d;
    logic [9:0]           addr_q, addr_d;
    logic [MAX_LEN_W-1:0] remaining_q, remaining_d;
    logic                 inc_q, inc_d;
    logic                 inflight_q, inflight_d;
    logic                 inflight_rd_q, inflight_rd_d;
    logic [15:0]          cap_q, cap_d;
    logic                 req_ready_q, req_ready_d;
    logic [15:0]          rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic [10:0]          ctrl_addr_q, ctrl_addr_d;
    logic [15:0]          ctrl_wr_data_q, ctrl_wr_data_d;

    // Next-state, beat issue, in-flight tracking and read capture.
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        addr_d         = addr_q;
        remaining_d    = remaining_q;
        inc_d          = inc_q;
        inflight_d     = inflight_q;
        inflight_rd_d  = inflight_rd_q;
        cap_d          = cap_q;
        ctrl_addr_d    = ctrl_addr_q;
        ctrl_wr_data_d = ctrl_wr_data_q;
        rd_data_d      = rd_data_q;
        rd_valid_d     = 1'b0;
        done_d         = 1'b0;

        // A launch edge retires the previous access; the idle default is loaded unless a beat overrides it.
        if (ctrl_op_state) begin
            ctrl_addr_d   = IDLE_CMD;
            inflight_d    = 1'b0;
            inflight_rd_d = 1'b0;
            if (inflight_q && inflight_rd_q) begin
                rd_data_d  = cap_q;
                rd_valid_d = 1'b1;
            end else begin
                rd_data_d  = rd_data_q;
            end
        end else if (inflight_q && inflight_rd_q) begin
            cap_d = ctrl_rd_data;
        end else begin
            cap_d = cap_q;
        end

        case (state_q)
            SEQ_WAIT_INIT: begin
                if (ctrl_op_state) begin
                    state_d = SEQ_IDLE;
                end else begin
                    state_d = SEQ_WAIT_INIT;
                end
            end
            SEQ_IDLE: begin
                if (req_valid && req_ready_q) begin
                    op_d        = addr_operation_e'(req_op);
                    addr_d      = req_addr;
                    remaining_d = req_len;
                    inc_d       = req_inc;
                    if (req_len == {MAX_LEN_W{1'b0}}) begin
                        done_d  = 1'b1;
                        state_d = SEQ_IDLE;
                    end else begin
                        state_d = SEQ_BURST;
                    end
                end else begin
                    state_d = SEQ_IDLE;
                end
            end
            SEQ_BURST: begin
                // A write beat without data leaves the idle default in place (bubble).
                if (ctrl_op_state && ((op_q == ADDR_OP_RD) || wr_valid)) begin
                    ctrl_addr_d   = {op_q, addr_q};
                    inflight_d    = 1'b1;
                    inflight_rd_d = (op_q == ADDR_OP_RD);
                    addr_d        = next_addr(addr_q, inc_q);
                    remaining_d   = remaining_q - LEN_ONE;
                    if (op_q == ADDR_OP_WR) begin
                        ctrl_wr_data_d = wr_data;
                    end else begin
                        ctrl_wr_data_d = ctrl_wr_data_q;
                    end
                    if (remaining_q == LEN_ONE) begin
                        state_d = SEQ_DRAIN;
                    end else begin
                        state_d = SEQ_BURST;
                    end
                end else begin
                    state_d = SEQ_BURST;
                end
            end
            SEQ_DRAIN: begin
                if (ctrl_op_state) begin
                    done_d  = 1'b1;
                    state_d = SEQ_IDLE;
                end else begin
                    state_d = SEQ_DRAIN;
                end
            end
            default: begin
                state_d = SEQ_WAIT_INIT;
            end
        endcase

        req_ready_d = (state_d == SEQ_IDLE);
        busy_d      = (state_d == SEQ_BURST) || (state_d == SEQ_DRAIN);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= SEQ_WAIT_INIT;
            op_q           <= ADDR_OP_RD;
            addr_q         <= 10'h000;
            remaining_q    <= {MAX_LEN_W{1'b0}};
            inc_q          <= 1'b0;
            inflight_q     <= 1'b0;
            inflight_rd_q  <= 1'b0;
            cap_q          <= 16'h0000;
            req_ready_q    <= 1'b0;
            rd_data_q      <= 16'h0000;
            rd_valid_q     <= 1'b0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
            ctrl_addr_q    <= IDLE_CMD;
            ctrl_wr_data_q <= 16'h0000;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            addr_q         <= addr_d;
            remaining_q    <= remaining_d;
            inc_q          <= inc_d;
            inflight_q     <= inflight_d;
            inflight_rd_q  <= inflight_rd_d;
            cap_q          <= cap_d;
            req_ready_q    <= req_ready_d;
            rd_data_q      <= rd_data_d;
            rd_valid_q     <= rd_valid_d;
            done_q         <= done_d;
            busy_q         <= busy_d;
            ctrl_addr_q    <= ctrl_addr_d;
            ctrl_wr_data_q <= ctrl_wr_data_d;
        end
    end

    // Write consumption must coincide with the launch edge, so it cannot be delayed a cycle.
    assign wr_ready = (state_q == SEQ_BURST) && (op_q == ADDR_OP_WR) && ctrl_op_state &&
                      (remaining_q != {MAX_LEN_W{1'b0}});

    assign req_ready    = req_ready_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign done         = done_q;
    assign busy         = busy_q;
    assign ctrl_addr    = ctrl_addr_q;
    assign ctrl_wr_data = ctrl_wr_data_q;

endmodule

// File: tb/tb_w5300_reg_seq.sv
// Self-checking bench for w5300_reg_seq: behavioural interface model, access
// log and read scoreboard, table-driven bursts, corner sequences, random bursts.
module tb_w5300_reg_seq;
    import w5300_reg_seq_pkg::*;

    localparam logic [10:0] IDLE_CMD = 11'h000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_op, req_inc;
    logic [9:0]  req_addr;
    logic [7:0]  req_len;
    logic [15:0] wr_data, rd_data, ctrl_wr_data, ctrl_rd_data;
    logic        wr_valid, wr_ready, rd_valid, done, busy, ctrl_op_state;
    logic [10:0] ctrl_addr;

    int n_tests = 0, n_fail = 0;
    int done_cnt = 0, wr_hs_cnt = 0, launch_cnt = 0, bubble_cnt = 0;
    bit iface_en = 1'b0, cur_rd = 1'b0;
    int wr_mode = 0;
    logic [15:0] wr_q[$], rd_resp[$], exp_rd[$], log_data[$];
    logic [10:0] log_cmd[$];

    w5300_reg_seq #(.IDLE_ADDR(10'h000), .MAX_LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_len(req_len), .req_inc(req_inc),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .busy(busy),
        .ctrl_addr(ctrl_addr), .ctrl_wr_data(ctrl_wr_data),
        .ctrl_rd_data(ctrl_rd_data), .ctrl_op_state(ctrl_op_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Interface model: one Idle cycle launches an access, followed by 1..3 busy cycles.
    logic [10:0] acc_cmd;
    logic [15:0] acc_wd, cur_val;
    int          cnt = 1;
    bit          in_acc = 1'b0, prev_busy = 1'b0, is_user;
    initial begin
        ctrl_op_state = 1'b0;
        ctrl_rd_data  = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (!iface_en) begin
                ctrl_op_state = 1'b0;
                in_acc        = 1'b0;
                cnt           = 1;
            end else if (ctrl_op_state) begin
                acc_cmd = ctrl_addr;
                acc_wd  = ctrl_wr_data;
                launch_cnt++;
                // A read of the idle address is a user beat only when it is launched mid-burst of a read burst.
                is_user = (acc_cmd != IDLE_CMD) || (prev_busy && busy && cur_rd);
                if ((acc_cmd == IDLE_CMD) && prev_busy && busy && !cur_rd) bubble_cnt++;
                cur_val = 16'($urandom);
                if (is_user) begin
                    log_cmd.push_back(acc_cmd);
                    log_data.push_back(acc_wd);
                    if (acc_cmd[10] == 1'b0) begin
                        if (rd_resp.size() > 0) cur_val = rd_resp.pop_front();
                        exp_rd.push_back(cur_val);
                    end
                end
                in_acc        = 1'b1;
                cnt           = $urandom_range(1, 3);
                ctrl_op_state = 1'b0;
                ctrl_rd_data  = (cnt == 1) ? cur_val : 16'($urandom);
            end else begin
                if (in_acc) begin
                    check("ctrl_addr_stable", {21'd0, ctrl_addr}, {21'd0, acc_cmd});
                    check("ctrl_wr_data_stable", {16'd0, ctrl_wr_data}, {16'd0, acc_wd});
                end
                cnt--;
                if (cnt <= 0) ctrl_op_state = 1'b1;
                else ctrl_rd_data = (cnt == 1) ? cur_val : 16'($urandom);
            end
            prev_busy = busy;
        end
    end

    // Write source: presents queued words, optionally with random gaps.
    logic wr_hs_s;
    initial begin
        wr_valid = 1'b0;
        wr_data  = 16'h0000;
        forever begin
            @(negedge clk);
            wr_hs_s = wr_valid && wr_ready;
            @(posedge clk);
            #1;
            if (wr_hs_s) begin
                wr_hs_cnt++;
                if (wr_q.size() > 0) void'(wr_q.pop_front());
            end
            if ((wr_q.size() > 0) && ((wr_mode == 0) || ((wr_mode == 1) && ($urandom_range(0, 1) == 1)))) begin
                wr_valid = 1'b1;
                wr_data  = wr_q[0];
            end else begin
                wr_valid = 1'b0;
                wr_data  = 16'($urandom);
            end
        end
    end

    // Output monitor: counts done pulses and scores every rd_valid.
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (rd_valid === 1'b1) begin
                if (exp_rd.size() == 0) check("rd_valid_spurious", {31'd0, rd_valid}, 32'd0);
                else check("rd_data", {16'd0, rd_data}, {16'd0, exp_rd.pop_front()});
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "bench timeout");
    end

    task automatic issue_req(input logic op, input logic [9:0] addr, input int len, input logic inc);
        int t;
        t = 0;
        @(negedge clk);
        while ((req_ready !== 1'b1) && (t < 500)) begin
            @(negedge clk);
            t++;
        end
        check("req_ready_wait", {31'd0, req_ready}, 32'd1);
        req_op    = op;
        req_addr  = addr;
        req_len   = 8'(len);
        req_inc   = inc;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((done !== 1'b1) && (t < 3000)) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd0);
        check({tag, "_wr_ready"}, {31'd0, wr_ready}, 32'd0);
        check({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_rd_data"}, {16'd0, rd_data}, 32'd0);
        check({tag, "_ctrl_addr"}, {21'd0, ctrl_addr}, {21'd0, IDLE_CMD});
        check({tag, "_ctrl_wr_data"}, {16'd0, ctrl_wr_data}, 32'd0);
    endtask

    // One complete burst checked against the closed-form access list.
    task automatic run_burst(input logic op, input logic [9:0] addr, input int len, input logic inc,
                             input int wmode, output int n_acc, output logic [9:0] last_addr);
        logic [15:0] words[$];
        logic [9:0]  exp_a;
        int          dc0, hs0;
        for (int k = 0; k < len; k++) begin
            words.push_back(16'($urandom));
            if (op == ADDR_OP_WR) wr_q.push_back(words[k]);
        end
        wr_mode = wmode;
        log_cmd.delete();
        log_data.delete();
        cur_rd = (op == ADDR_OP_RD);
        dc0 = done_cnt;
        hs0 = wr_hs_cnt;
        issue_req(op, addr, len, inc);
        if (len == 0) begin
            check("len0_done", {31'd0, done}, 32'd1);
            check("len0_busy", {31'd0, busy}, 32'd0);
            @(negedge clk);
            check("len0_done_pulse", {31'd0, done}, 32'd0);
        end else begin
            check("busy_start", {31'd0, busy}, 32'd1);
            wait_done();
            if (op == ADDR_OP_RD) check("rd_valid_with_done", {31'd0, rd_valid}, 32'd1);
            @(negedge clk);
            check("busy_end", {31'd0, busy}, 32'd0);
            check("done_pulse", {31'd0, done}, 32'd0);
        end
        repeat (8) @(negedge clk);
        check("done_count", done_cnt - dc0, 32'd1);
        check("n_accesses", log_cmd.size(), len);
        for (int k = 0; (k < len) && (k < log_cmd.size()); k++) begin
            exp_a = addr & 10'h3FE;
            if (inc) exp_a = exp_a + 10'(2 * k);
            exp_a = exp_a | {9'd0, addr[0]};
            check("access_cmd", {21'd0, log_cmd[k]}, {21'd0, op, exp_a});
            if (op == ADDR_OP_WR) check("access_wdata", {16'd0, log_data[k]}, {16'd0, words[k]});
        end
        if (op == ADDR_OP_WR) check("wr_handshakes", wr_hs_cnt - hs0, len);
        check("reads_pending", exp_rd.size(), 32'd0);
        n_acc = log_cmd.size();
        last_addr = (log_cmd.size() > 0) ? log_cmd[log_cmd.size() - 1][9:0] : 10'h000;
    endtask

    typedef struct {
        logic       op;
        logic [9:0] addr;
        int         len;
        logic       inc;
        int         exp_n;
        logic [9:0] exp_last;
    } vec_t;

    vec_t        tbl[6];
    int          n_acc, dc0, hs0, bub0, l0, t;
    logic [9:0]  last_a;

    initial begin
        tbl[0] = '{1'b0, 10'h018, 3, 1'b1, 3, 10'h01C};
        tbl[1] = '{1'b1, 10'h22E, 4, 1'b0, 4, 10'h22E};
        tbl[2] = '{1'b0, 10'h3FE, 2, 1'b1, 2, 10'h000};
        tbl[3] = '{1'b1, 10'h040, 0, 1'b1, 0, 10'h000};
        tbl[4] = '{1'b1, 10'h101, 3, 1'b1, 3, 10'h105};
        tbl[5] = '{1'b0, 10'h3FD, 3, 1'b1, 3, 10'h001};

        rst_n = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_addr = 10'h000; req_len = 8'd0; req_inc = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Interface still in its reset phases: no acceptance, idle default on the bus.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("init_req_ready", {31'd0, req_ready}, 32'd0);
            check("init_ctrl_addr", {21'd0, ctrl_addr}, {21'd0, IDLE_CMD});
        end
        iface_en = 1'b1;
        t = 0;
        while ((req_ready !== 1'b1) && (t < 20)) begin
            @(negedge clk);
            t++;
        end
        check("init_ready_rises", {31'd0, req_ready}, 32'd1);
        check("init_after_idle_edge", {31'd0, (launch_cnt >= 1)}, 32'd1);

        for (int i = 0; i < 6; i++) begin
            rd_resp.delete();
            if (tbl[i].op == ADDR_OP_RD)
                for (int k = 0; k < tbl[i].len; k++) rd_resp.push_back(16'(16'h1111 * (k + 1)));
            run_burst(tbl[i].op, tbl[i].addr, tbl[i].len, tbl[i].inc, 0, n_acc, last_a);
            check("tbl_n_acc", n_acc, tbl[i].exp_n);
            if (tbl[i].exp_n > 0) check("tbl_last_addr", {22'd0, last_a}, {22'd0, tbl[i].exp_last});
        end

        // Write burst whose second word arrives three interface cycles late.
        rd_resp.delete();
        log_cmd.delete();
        log_data.delete();
        cur_rd = 1'b0;
        wr_mode = 0;
        wr_q.push_back(16'hBEEF);
        dc0 = done_cnt; hs0 = wr_hs_cnt; bub0 = bubble_cnt;
        issue_req(1'b1, 10'h150, 2, 1'b1);
        t = 0;
        while ((wr_hs_cnt == hs0) && (t < 200)) begin
            @(negedge clk);
            t++;
        end
        check("gap_first_word", wr_hs_cnt - hs0, 32'd1);
        l0 = launch_cnt;
        t = 0;
        while ((launch_cnt < l0 + 3) && (t < 200)) begin
            @(negedge clk);
            t++;
        end
        wr_q.push_back(16'h1234);
        wait_done();
        repeat (8) @(negedge clk);
        check("gap_bubbles", bubble_cnt - bub0, 32'd3);
        check("gap_writes", log_cmd.size(), 32'd2);
        if (log_cmd.size() == 2) begin
            check("gap_cmd0", {21'd0, log_cmd[0]}, {21'd0, 11'h550});
            check("gap_cmd1", {21'd0, log_cmd[1]}, {21'd0, 11'h552});
            check("gap_data0", {16'd0, log_data[0]}, 32'h0000BEEF);
            check("gap_data1", {16'd0, log_data[1]}, 32'h00001234);
        end
        check("gap_done_count", done_cnt - dc0, 32'd1);
        check("gap_handshakes", wr_hs_cnt - hs0, 32'd2);

        // Reset after the first of four write beats.
        for (int k = 0; k < 4; k++) wr_q.push_back(16'(16'hA0 + k));
        wr_mode = 0;
        dc0 = done_cnt; hs0 = wr_hs_cnt;
        issue_req(1'b1, 10'h0A0, 4, 1'b1);
        t = 0;
        while ((wr_hs_cnt == hs0) && (t < 200)) begin
            @(negedge clk);
            t++;
        end
        rst_n = 1'b0;
        iface_en = 1'b0;
        #1;
        check_reset_values("midreset");
        wr_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        iface_en = 1'b1;
        repeat (10) @(negedge clk);
        check("midreset_no_done", done_cnt - dc0, 32'd0);
        run_burst(1'b1, 10'h0A0, 4, 1'b1, 1, n_acc, last_a);
        check("post_reset_last", {22'd0, last_a}, 32'h000000A6);

        // Random bursts with random write gaps.
        for (int i = 0; i < 30; i++) begin
            rd_resp.delete();
            run_burst(1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)), $urandom_range(0, 5),
                      1'($urandom_range(0, 1)), $urandom_range(0, 1), n_acc, last_a);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/w5300_reg_seq.md
Name: w5300_reg_seq

Overview:
- Burst register-access sequencer directly upstream of the W5300 bus interface block.
- Accepts read/write burst requests, with optional address auto-increment, from the socket/config layer.
- Converts each request into one interface access per word on ctrl_addr/ctrl_wr_data.
- Streams write data in and read data out, and reports burst completion.

Parameters:
IDLE_ADDR, 10'h000, address presented with a RD op whenever no user beat is pending (harmless mode-register read)
MAX_LEN_W, 8, width of req_len

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  burst request valid
req_ready  out  1  sequencer can accept a request
req_op  in  1  W5300::AddrOperation (WR/RD)
req_addr  in  10  start byte address
req_len  in  MAX_LEN_W  word count; 0 = no access
req_inc  in  1  1: address += 2 per beat; 0: fixed address (FIFO regs)
wr_data  in  16  write word
wr_valid  in  1  write word valid
wr_ready  out  1  write word consumed this cycle
rd_data  out  16  read word
rd_valid  out  1  one-cycle pulse, no backpressure
done  out  1  one-cycle pulse at burst completion
busy  out  1  burst in progress
ctrl_addr  out  11  {op, addr} to interface, registered
ctrl_wr_data  out  16  to interface, registered
ctrl_rd_data  in  16  from interface
ctrl_op_state  in  1  1 = interface Idle

Behaviour:
- One clock clk; reset rst_n is asynchronous, active-low. Reset mid-burst aborts the burst; no done pulse is issued.
- Reset values:
  - req_ready=0, wr_ready=0, rd_valid=0, done=0, busy=0, rd_data=0.
  - ctrl_addr={RD, IDLE_ADDR}, ctrl_wr_data=0.
- Access rule:
  - The interface launches one access on every clock edge where ctrl_op_state==1.
  - That access runs over the following ctrl_op_state==0 cycles.
  - ctrl_addr and ctrl_wr_data update ONLY on such edges, so they are stable for the whole access window.
  - Each such edge loads either the next user beat or {RD, IDLE_ADDR}.
- States:
  - WaitInit: entered from reset; waits for the first ctrl_op_state==1 (interface reset phases done), then goes to Idle.
  - Idle: req_ready=1. On req_valid:
    - latch op, addr, len, inc;
    - if len==0, pulse done next cycle and stay Idle;
    - otherwise go to Burst with busy=1.
  - Burst: on each edge with ctrl_op_state==1, issue a beat:
    - RD beat: always issued.
    - WR beat: issued only if wr_valid. wr_ready = (state==Burst) & op==WR & ctrl_op_state & remaining>0, and ctrl_wr_data<=wr_data on that edge.
    - If a WR beat has no wr_valid, load {RD, IDLE_ADDR} instead (bubble); no beat is consumed and no write is ever issued with stale data.
    - After issuing the last beat, go to Drain.
  - Drain: wait for the next ctrl_op_state==1 edge, which completes the last access; load the idle default; pulse done; go to Idle with busy=0.
- Address: when inc=1, add 2 after each issued beat, 10-bit wrap (3FE→000). bit0 is passed through unchanged.
- Read capture:
  - While a user RD access is in flight, register ctrl_rd_data on every ctrl_op_state==0 cycle; the last value wins.
  - On the completing ctrl_op_state==1 edge, rd_data takes the captured value and rd_valid pulses.
  - For RD bursts, the last rd_valid and done assert in the same cycle.
- Throughput: one beat per interface cycle (Idle + access window); no extra idle accesses between back-to-back beats.
- Beat counter: MAX_LEN_W bits, decrements on issue; remaining==0 means the issue phase is complete.
- Idle-default RD accesses never produce rd_valid.

Decomposition:
- Package W5300:
  - reuse AddrOperation / WR / RD;
  - add a SeqState enum (WaitInit, Idle, Burst, Drain);
  - add localparam ADDR_STEP=2.
- No sub-module. The in-flight tracker (flag plus is-read bit) stays inline.

Test Plan:
- Reset, hold ctrl_op_state=0 for 100 cycles, then 1 → req_ready rises only after the first op_state=1; ctrl_addr=={RD,10'h000} throughout.
- RD burst addr=0x018, len=3, inc=1; model returns 0x1111/0x2222/0x3333 → exactly 3 user accesses at 0x018/0x01A/0x01C; rd_valid ×3 with those values; done coincident with the third rd_valid.
- WR burst addr=0x22E, len=4, inc=0; wr_valid always high, data A0..A3 → 4 WR accesses all at 0x22E, data stable across each access window; wr_ready 4 pulses; done once.
- WR burst len=2 with wr_valid low for 3 interface cycles before the second word → idle RD bubbles appear in between; no WR is issued with stale data; 2 writes total.
- inc=1, addr=0x3FE, len=2 RD → accesses at 0x3FE then 0x000; req_len=0 → done one cycle after accept and zero accesses.
- Assert rst_n low mid WR burst (after 1 of 4 beats) → outputs return to reset values; no done; the next request executes normally.
